io_master: RTL and testbench

//  CPU-side initiator for the 8-bit IO bus: turns one-cycle access requests from the

---
 rtl/io_master.sv | 219 +++++++++++++++++++++
 tb/tb_io_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_master.sv
// io_master: CPU-side initiator for the 8-bit IO bus.
// Turns one-cycle requests into timed IO bus cycles (SETUP -> STROBE -> HOLD) with
// registered, glitch-free strobes, and returns read data with a one-cycle o_done pulse.
// Optional feature macro: IO_WAIT_EN adds i_ioNWait (peripheral wait) and o_timeout.
module io_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int WAIT_MAX      = 8
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_req,
  input  logic       i_write,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  output logic       o_ioSelect,
  output logic [7:0] o_ioAddress,
  output logic       o_ioNOE,
  output logic       o_ioNWE
`ifdef IO_WAIT_EN
  ,
  input  logic       i_ioNWait,
  output logic       o_timeout
`endif
);

  // Phase lengths below 1 are clamped to 1.
  localparam int SetupEff  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
  localparam int StrobeEff = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
  localparam int HoldEff   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
  localparam int WaitEff   = (WAIT_MAX      < 0) ? 0 : WAIT_MAX;

  // One counter width covers every phase length and the wait limit.
  localparam int MaxA   = (SetupEff > StrobeEff) ? SetupEff : StrobeEff;
  localparam int MaxB   = (HoldEff > WaitEff) ? HoldEff : WaitEff;
  localparam int MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] SetupLd  = CntW'(SetupEff - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(StrobeEff - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HoldEff - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            sel_q, sel_d;
  logic [7:0]      addr_q, addr_d;
  logic            noe_q, noe_d;
  logic            nwe_q, nwe_d;
  logic            busnoe_q, busnoe_d;
  logic [7:0]      bus_q, bus_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            end_strobe;

`ifdef IO_WAIT_EN
  localparam logic [CntW-1:0] WaitLim = CntW'(WaitEff);
  logic [CntW-1:0] wcnt_q, wcnt_d;
  logic            to_q, to_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state and next-output decode; every bus output is registered from here.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    noe_d      = noe_q;
    nwe_d      = nwe_q;
    busnoe_d   = busnoe_q;
    bus_d      = bus_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    end_strobe = 1'b0;
`ifdef IO_WAIT_EN
    wcnt_d     = wcnt_q;
    to_d       = to_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          wr_d    = i_write;
          sel_d   = 1'b1;
          addr_d  = i_addr;
          if (i_write) begin
            bus_d    = i_wdata;
            busnoe_d = 1'b0;
          end
`ifdef IO_WAIT_EN
          to_d = 1'b0;
`endif
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLd;
          noe_d   = wr_q;
          nwe_d   = !wr_q;
`ifdef IO_WAIT_EN
          wcnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          end_strobe = 1'b1;
`ifdef IO_WAIT_EN
          // Extend the strobe while the peripheral holds wait low, up to the limit.
          if (!i_ioNWait) begin
            if (wcnt_q == WaitLim) begin
              to_d = 1'b1;
            end else begin
              end_strobe = 1'b0;
              wcnt_d     = wcnt_q + CntW'(1);
            end
          end
`endif
          if (end_strobe) begin
            state_d = StHold;
            cnt_d   = HoldLd;
            noe_d   = 1'b1;
            nwe_d   = 1'b1;
            if (!wr_q) begin
              rdata_d = i_bus;
            end
          end
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d  = StIdle;
          sel_d    = 1'b0;
          busnoe_d = 1'b1;
          done_d   = 1'b1;
`ifdef IO_WAIT_EN
          timeout_d = to_q;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      sel_q    <= 1'b0;
      addr_q   <= 8'h00;
      noe_q    <= 1'b1;
      nwe_q    <= 1'b1;
      busnoe_q <= 1'b1;
      bus_q    <= 8'h00;
      rdata_q  <= 8'h00;
      done_q   <= 1'b0;
`ifdef IO_WAIT_EN
      wcnt_q    <= '0;
      to_q      <= 1'b0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      noe_q    <= noe_d;
      nwe_q    <= nwe_d;
      busnoe_q <= busnoe_d;
      bus_q    <= bus_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
`ifdef IO_WAIT_EN
      wcnt_q    <= wcnt_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_bus       = bus_q;
  assign o_busNOE    = busnoe_q;
  assign o_ioSelect  = sel_q;
  assign o_ioAddress = addr_q;
  assign o_ioNOE     = noe_q;
  assign o_ioNWE     = nwe_q;
`ifdef IO_WAIT_EN
  assign o_timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_io_master.sv
// Bench for io_master: random accesses against a transaction-level model, checked by a
// scoreboard monitor on o_done; plus reset-abort and non-default timing checks.
module tb_io_master;

  localparam int S  = 1;
  localparam int T  = 2;
  localparam int H  = 1;
  localparam int WM = 8;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         k;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_req, i_write;
  logic [7:0] i_addr, i_wdata;
  logic       o_busy, o_done;
  logic [7:0] o_rdata, i_bus, o_bus, o_ioAddress;
  logic       o_busNOE, o_ioSelect, o_ioNOE, o_ioNWE;
  logic       d1_nwait;
  logic       o_timeout;

  // Second instance with stretched setup/hold and a one-cycle strobe.
  logic       r2_req, r2_write;
  logic [7:0] r2_addr, r2_wdata;
  logic       d2_busy, d2_done;
  logic [7:0] d2_rdata, d2_bus_in, d2_bus, d2_addr;
  logic       d2_busnoe, d2_sel, d2_noe, d2_nwe;
  logic [7:0] d2_periph;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Peripheral model: drives its data only while the read strobe is low.
  logic [7:0] periph_data = 8'h00;
  int         k_cur = 0;
  int         scnt;
  logic       strobe1;

  always #5 clk = ~clk;

  io_master dut (
    .i_clk(clk), .i_resetn(rstn), .i_req(i_req), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .i_bus(i_bus),
    .o_bus(o_bus), .o_busNOE(o_busNOE), .o_ioSelect(o_ioSelect), .o_ioAddress(o_ioAddress),
    .o_ioNOE(o_ioNOE), .o_ioNWE(o_ioNWE)
`ifdef IO_WAIT_EN
    , .i_ioNWait(d1_nwait), .o_timeout(o_timeout)
`endif
  );

  io_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) dut2 (
    .i_clk(clk), .i_resetn(rstn), .i_req(r2_req), .i_write(r2_write), .i_addr(r2_addr),
    .i_wdata(r2_wdata), .o_busy(d2_busy), .o_done(d2_done), .o_rdata(d2_rdata),
    .i_bus(d2_bus_in), .o_bus(d2_bus), .o_busNOE(d2_busnoe), .o_ioSelect(d2_sel),
    .o_ioAddress(d2_addr), .o_ioNOE(d2_noe), .o_ioNWE(d2_nwe)
`ifdef IO_WAIT_EN
    , .i_ioNWait(1'b1), .o_timeout()
`endif
  );

  assign strobe1   = !o_ioNOE || !o_ioNWE;
  assign i_bus     = o_ioNOE ? ~periph_data : periph_data;
  assign d2_bus_in = d2_noe ? ~d2_periph : d2_periph;
  // Wait held low for k_cur strobe cycles starting at the last nominal strobe cycle.
  assign d1_nwait  = !(strobe1 && (scnt >= T - 1) && (scnt < T - 1 + k_cur));

`ifndef IO_WAIT_EN
  assign o_timeout = 1'b0;
`endif

  // Counts completed strobe-low cycles of the current access.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) scnt <= 0;
    else if (strobe1) scnt <= scnt + 1;
    else scnt <= 0;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard monitor: accumulates per-access observations, compares on o_done.
  int         m_cyc = 0;
  int         m_strb = 0;
  int         m_err = 0;
  logic [7:0] last_rd = 8'h00;
  initial begin
    exp_t cur;
    int   extra;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_cyc = 0; m_strb = 0; m_err = 0; last_rd = 8'h00;
      end else begin
        if (!o_ioNOE && !o_ioNWE) m_err = m_err | 1;
        if (o_timeout && !o_done) m_err = m_err | 32;
        if (o_busy) begin
          m_cyc++;
          if (strobe1) m_strb++;
          if (o_done) m_err = m_err | 2;
          if (sb.size() != 0) begin
            if (!o_ioSelect || o_ioAddress != sb[0].addr) m_err = m_err | 4;
            if (sb[0].wr) begin
              if (o_busNOE || o_bus != sb[0].data || !o_ioNOE) m_err = m_err | 8;
            end else if (!o_busNOE || !o_ioNWE) begin
              m_err = m_err | 8;
            end
          end else begin
            m_err = m_err | 16;
          end
        end
        if (o_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            cur   = sb.pop_front();
            extra = (cur.k > WM) ? WM : cur.k;
            chk("latency", m_cyc, S + T + H + extra);
            chk("strobe_cycles", m_strb, T + extra);
            chk("protocol_flags", m_err, 0);
            chk("sel_released", int'(o_ioSelect), 0);
            chk("busnoe_released", int'(o_busNOE), 1);
            chk("addr_held", int'(o_ioAddress), int'(cur.addr));
            if (!cur.wr) last_rd = cur.data;
            chk("rdata", int'(o_rdata), int'(last_rd));
`ifdef IO_WAIT_EN
            chk("timeout", int'(o_timeout), (cur.k > WM) ? 1 : 0);
`endif
          end
          m_cyc = 0; m_strb = 0; m_err = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where o_done is seen.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input int k,
                       input bit b2b, input bit junk);
    exp_t e;
    int   n;
    if (!b2b) begin
      n = 0;
      while (o_busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("idle_timeout", 1, 0);
    end
    i_req = 1'b1; i_write = w; i_addr = a; i_wdata = d;
    periph_data = d; k_cur = k;
    e.wr = w; e.addr = a; e.data = d; e.k = k;
    sb.push_back(e);
    @(negedge clk);
    i_req = 1'b0; i_addr = 8'($urandom); i_wdata = 8'($urandom); i_write = 1'($urandom);
    if (junk) begin
      i_req = 1'b1;
      @(negedge clk);
      i_req = 1'b0;
    end
    n = 0;
    while (!o_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 1, 0);
  endtask

  // Drives one access into dut2 and measures it directly.
  task automatic run_dut2(input logic w, input logic [7:0] a, input logic [7:0] d);
    int lat, strb, n;
    r2_req = 1'b1; r2_write = w; r2_addr = a; r2_wdata = d; d2_periph = d;
    @(negedge clk);
    r2_req = 1'b0;
    lat = 0; strb = 0; n = 0;
    while (!d2_done && n < 50) begin
      if (d2_busy) lat++;
      if (!d2_noe || !d2_nwe) strb++;
      @(negedge clk);
      n++;
    end
    chk("d2_latency", lat, 6);
    chk("d2_strobe_cycles", strb, 1);
    if (!w) chk("d2_rdata", int'(d2_rdata), int'(d));
    chk("d2_sel_released", int'(d2_sel), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int saw;
    int n;
    rstn = 1'b0;
    i_req = 1'b0; i_write = 1'b0; i_addr = 8'h00; i_wdata = 8'h00;
    r2_req = 1'b0; r2_write = 1'b0; r2_addr = 8'h00; r2_wdata = 8'h00; d2_periph = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", int'(o_ioSelect), 0);
    chk("rst_addr", int'(o_ioAddress), 0);
    chk("rst_noe", int'(o_ioNOE), 1);
    chk("rst_nwe", int'(o_ioNWE), 1);
    chk("rst_busnoe", int'(o_busNOE), 1);
    chk("rst_bus", int'(o_bus), 0);
    chk("rst_rdata", int'(o_rdata), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    issue(1'b1, 8'h00, 8'hA5, 0, 1'b0, 1'b0);
    issue(1'b0, 8'h00, 8'h3C, 0, 1'b1, 1'b1);
    issue(1'b1, 8'h7E, 8'h11, 0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int  k;
      bit  b2b;
      k = 0;
`ifdef IO_WAIT_EN
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 11)) : 0;
      if (i == 5) k = 3;
      if (i == 6) k = WM;
      if (i == 7) k = 20;
`endif
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), 8'($urandom), 8'($urandom), k, b2b, 1'($urandom));
    end

    // Reset in the middle of a write strobe aborts the access.
    @(negedge clk);
    k_cur = 0;
    i_req = 1'b1; i_write = 1'b1; i_addr = 8'h42; i_wdata = 8'h99;
    periph_data = 8'h99;
    sb.push_back('{wr: 1'b1, addr: 8'h42, data: 8'h99, k: 0});
    @(negedge clk);
    i_req = 1'b0;
    n = 0;
    while (o_ioNWE && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("nwe_low_before_reset", int'(o_ioNWE), 0);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_nwe", int'(o_ioNWE), 1);
    chk("abort_busnoe", int'(o_busNOE), 1);
    chk("abort_sel", int'(o_ioSelect), 0);
    chk("abort_busy", int'(o_busy), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_done) saw = 1;
    end
    chk("no_done_after_abort", saw, 0);

    run_dut2(1'b0, 8'h10, 8'h5A);
    run_dut2(1'b1, 8'h20, 8'hC3);
    run_dut2(1'b0, 8'h30, 8'h96);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
